// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path.
//   NREG / ADDR_W / DATA_W : register file geometry
//   wb_src_e               : encoding of the writeback source (ALU = 0, MEM = 1)
//   STARVE_W / STARVE_SAT  : width and saturation value of the ALU denial counter
package regfile_pkg;

  localparam int NREG   = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

  localparam int             STARVE_W   = 3;
  localparam logic [STARVE_W-1:0] STARVE_SAT = 3'd7;

endpackage

// File: rtl/regsel_decoder.sv
// Combinational register-select decoder.
// Turns a register address into a one-hot select vector. Address 0 decodes to
// all zeros because R0 is hardwired to zero; this keeps it reusable for the
// read-port selects as well as the write select.
//   addr : register address (ADDR_W bits)
//   sel  : one-hot select, or zero for addr 0 (NREG bits)
module regsel_decoder #(
  parameter int NREG   = 32,
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [NREG-1:0]   sel
);

  always_comb begin
    // NOTE: assign every bit before any conditional logic so no latch is inferred.
    sel = '0;
    for (int k = 1; k < NREG; k++) begin
      sel[k] = (addr == ADDR_W'(k));
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file's single write port.
// Chooses between the ALU result path and the load path each cycle; loads win
// ties unless the ALU has been denied STARVE_MAX times in a row. The winner's
// destination is decoded to a one-hot Dselect and registered together with the
// write data, so the register file sees the write one cycle after the grant.
//   clk, reset                       : clock, asynchronous active-high reset
//   alu_valid/addr/data, alu_ready   : ALU writeback request and grant
//   mem_valid/addr/data, mem_ready   : load writeback request and grant
//   Dselect, dbus                    : registered write select and write data
//   wb_src                           : source of the current Dselect/dbus
//   starve_cnt                       : consecutive ALU denials
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int NREG       = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              mem_ready,
  output logic [NREG-1:0]   Dselect,
  output logic [DATA_W-1:0] dbus,
  output logic              wb_src,
  output logic [2:0]        starve_cnt
);

  import regfile_pkg::*;

  logic [STARVE_W-1:0] starve_q;
  logic                starve_hit;
  logic                grant;
  wb_src_e             sel_src;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;
  logic [NREG-1:0]     dec_sel;

  assign starve_hit = (starve_q >= STARVE_W'(STARVE_MAX));

  // Grants are combinational so a requester can be replaced every cycle.
  // Both readies are forced low during reset.
  always_comb begin
    mem_ready = !reset && mem_valid && (!alu_valid || !starve_hit);
    alu_ready = !reset && alu_valid && (!mem_valid || starve_hit);
    grant     = alu_ready || mem_ready;
    sel_src   = mem_ready ? WB_SRC_MEM : WB_SRC_ALU;
    sel_addr  = mem_ready ? mem_addr : alu_addr;
    sel_data  = mem_ready ? mem_data : alu_data;
  end

  regsel_decoder #(
    .NREG   (NREG),
    .ADDR_W (ADDR_W)
  ) u_dec (
    .addr (sel_addr),
    .sel  (dec_sel)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Dselect  <= '0;
      dbus     <= '0;
      wb_src   <= WB_SRC_ALU;
      starve_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      // Dselect is a one-cycle strobe; dbus/wb_src hold when nothing is granted.
      Dselect <= grant ? dec_sel : '0;
      if (grant) begin
        dbus   <= sel_data;
        wb_src <= sel_src;
      end
      // Counts only cycles where the ALU asked and lost; any other cycle resets it.
      if (alu_valid && !alu_ready) begin
        starve_q <= (starve_q == STARVE_SAT) ? starve_q : starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
    end
  end

  assign starve_cnt = starve_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        mem_valid = 1'b0;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        mem_ready;
  logic [31:0] Dselect;
  logic [31:0] dbus;
  logic        wb_src;
  logic [2:0]  starve_cnt;

  int passed = 0;
  int total  = 0;

  // Register file driven by the DUT write port.
  logic [31:0] rf [32];
  logic        rf_clear = 1'b1;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(
    .DATA_W(32), .NREG(32), .ADDR_W(5), .STARVE_MAX(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_ready  (mem_ready),
    .Dselect    (Dselect),
    .dbus       (dbus),
    .wb_src     (wb_src),
    .starve_cnt (starve_cnt)
  );

  always @(posedge clk) begin
    for (int k = 0; k < 32; k++) begin
      if (rf_clear) rf[k] <= '0;
      else if (Dselect[k]) rf[k] <= dbus;
    end
  end

  // Structural invariants, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      total++;
      if (!$onehot0(Dselect)) $display("FAIL dselect_onehot0: got %h want zero or one-hot", Dselect);
      else passed++;
      total++;
      if (alu_ready && mem_ready) $display("FAIL ready_exclusive: got alu=%0b mem=%0b want not both", alu_ready, mem_ready);
      else passed++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
  endtask

  task automatic test_reset();
    alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'h1111_1111;
    mem_valid = 1'b1; mem_addr = 5'd6; mem_data = 32'h2222_2222;
    #2;
    total++;
    if ({Dselect, dbus, wb_src, starve_cnt} !== '0) $display("FAIL reset_outputs: got Dselect=%h dbus=%h wb_src=%0b cnt=%0d want all 0", Dselect, dbus, wb_src, starve_cnt);
    else passed++;
    total++;
    if ({alu_ready, mem_ready} !== 2'b00) $display("FAIL reset_readies: got %b want 00", {alu_ready, mem_ready});
    else passed++;
    tick(); tick();
    idle();
    reset = 1'b0;
    rf_clear = 1'b0;
    tick();
  endtask

  task automatic test_alu_only();
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'h1234_5678;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL alu_only_ready: got %b want 10", {alu_ready, mem_ready});
    else passed++;
    tick();
    idle();
    total++;
    if ({Dselect, dbus, wb_src} !== {32'h0000_0020, 32'h1234_5678, 1'b0}) $display("FAIL alu_only_write: got Dselect=%h dbus=%h wb_src=%0b want 00000020 12345678 0", Dselect, dbus, wb_src);
    else passed++;
    tick();
    total++;
    if ({Dselect, dbus} !== {32'h0, 32'h1234_5678}) $display("FAIL idle_hold: got Dselect=%h dbus=%h want 00000000 12345678", Dselect, dbus);
    else passed++;
  endtask

  task automatic test_both();
    mem_valid = 1'b1; mem_addr = 5'd3; mem_data = 32'hAAAA_0000;
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h0000_BBBB;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b01) $display("FAIL both_first_ready: got %b want 01", {alu_ready, mem_ready});
    else passed++;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({Dselect, dbus, wb_src, starve_cnt} !== {32'h08, 32'hAAAA_0000, 1'b1, 3'd1}) $display("FAIL both_mem_write: got Dselect=%h dbus=%h wb_src=%0b cnt=%0d want 00000008 aaaa0000 1 1", Dselect, dbus, wb_src, starve_cnt);
    else passed++;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL both_second_ready: got %b want 10", {alu_ready, mem_ready});
    else passed++;
    tick();
    idle();
    total++;
    if ({Dselect, dbus, wb_src, starve_cnt} !== {32'h80, 32'h0000_BBBB, 1'b0, 3'd0}) $display("FAIL both_alu_write: got Dselect=%h dbus=%h wb_src=%0b cnt=%0d want 00000080 0000bbbb 0 0", Dselect, dbus, wb_src, starve_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_starvation();
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'h0A0A_0A0A;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1'b1; mem_addr = 5'(11 + i); mem_data = 32'h100 + i;
      #1;
      total++;
      if ({alu_ready, mem_ready} !== 2'b01) $display("FAIL starve_mem_ready[%0d]: got %b want 01", i, {alu_ready, mem_ready});
      else passed++;
      tick();
      total++;
      if ({starve_cnt, Dselect, wb_src} !== {3'(i + 1), 32'h1 << (11 + i), 1'b1}) $display("FAIL starve_mem_write[%0d]: got cnt=%0d Dselect=%h wb_src=%0b want %0d %h 1", i, starve_cnt, Dselect, wb_src, i + 1, 32'h1 << (11 + i));
      else passed++;
    end
    mem_addr = 5'd14; mem_data = 32'h0000_0E0E;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) $display("FAIL starve_alu_ready: got %b want 10", {alu_ready, mem_ready});
    else passed++;
    tick();
    alu_valid = 1'b0;
    total++;
    if ({starve_cnt, Dselect, dbus, wb_src} !== {3'd0, 32'h0000_0400, 32'h0A0A_0A0A, 1'b0}) $display("FAIL starve_alu_write: got cnt=%0d Dselect=%h dbus=%h wb_src=%0b want 0 00000400 0a0a0a0a 0", starve_cnt, Dselect, dbus, wb_src);
    else passed++;
    tick();
    mem_valid = 1'b0;
    total++;
    if ({Dselect, dbus, wb_src} !== {32'h0000_4000, 32'h0000_0E0E, 1'b1}) $display("FAIL starve_mem_after: got Dselect=%h dbus=%h wb_src=%0b want 00004000 00000e0e 1", Dselect, dbus, wb_src);
    else passed++;
    tick();
  endtask

  task automatic test_addr0();
    mem_valid = 1'b1; mem_addr = 5'd0; mem_data = 32'hDEAD_BEEF;
    #1;
    total++;
    if (mem_ready !== 1'b1) $display("FAIL addr0_ready: got %0b want 1", mem_ready);
    else passed++;
    tick();
    idle();
    total++;
    if ({Dselect, dbus, wb_src} !== {32'h0, 32'hDEAD_BEEF, 1'b1}) $display("FAIL addr0_write: got Dselect=%h dbus=%h wb_src=%0b want 00000000 deadbeef 1", Dselect, dbus, wb_src);
    else passed++;
    tick();
    total++;
    if (rf[0] !== 32'h0) $display("FAIL addr0_r0: got %h want 00000000", rf[0]);
    else passed++;
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      alu_valid = 1'b1; alu_addr = 5'(i); alu_data = 32'h1000 + i;
      #1;
      tick();
      total++;
      if ({Dselect, dbus} !== {32'h1 << i, 32'h1000 + i}) $display("FAIL b2b_write[%0d]: got Dselect=%h dbus=%h want %h %h", i, Dselect, dbus, 32'h1 << i, 32'h1000 + i);
      else passed++;
    end
    idle();
    tick();
    total++;
    if (Dselect !== 32'h0) $display("FAIL b2b_end: got Dselect=%h want 00000000", Dselect);
    else passed++;
  endtask

  task automatic test_reset_mid();
    alu_valid = 1'b1; alu_addr = 5'd9; alu_data = 32'h9999_9999;
    #1;
    tick();
    total++;
    if (Dselect !== 32'h0000_0200) $display("FAIL rstmid_pending: got Dselect=%h want 00000200", Dselect);
    else passed++;
    reset = 1'b1;
    #1;
    total++;
    if ({Dselect, dbus, wb_src, starve_cnt, alu_ready, mem_ready} !== '0) $display("FAIL rstmid_outputs: got Dselect=%h dbus=%h wb_src=%0b cnt=%0d rdy=%b want all 0", Dselect, dbus, wb_src, starve_cnt, {alu_ready, mem_ready});
    else passed++;
    tick();
    idle();
    total++;
    if (rf[9] !== 32'h0) $display("FAIL rstmid_r9: got %h want 00000000", rf[9]);
    else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] shadow [32];
    logic [2:0]  cnt_m;
    logic        a_pend, m_pend, ag, mg;
    rf_clear = 1'b1;
    tick();
    rf_clear = 1'b0;
    for (int k = 0; k < 32; k++) shadow[k] = '0;
    cnt_m = '0; a_pend = 1'b0; m_pend = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (!a_pend && $urandom_range(0, 3) != 0) begin
        a_pend = 1'b1; alu_addr = 5'($urandom_range(0, 31)); alu_data = $urandom;
      end
      if (!m_pend && $urandom_range(0, 3) != 0) begin
        m_pend = 1'b1; mem_addr = 5'($urandom_range(0, 31)); mem_data = $urandom;
      end
      alu_valid = a_pend;
      mem_valid = m_pend;
      mg = m_pend && (!a_pend || cnt_m < 3'd3);
      ag = a_pend && (!m_pend || cnt_m >= 3'd3);
      #1;
      total++;
      if ({alu_ready, mem_ready, starve_cnt} !== {ag, mg, cnt_m}) $display("FAIL rand_grant[%0d]: got rdy=%b cnt=%0d want rdy=%b cnt=%0d", c, {alu_ready, mem_ready}, starve_cnt, {ag, mg}, cnt_m);
      else passed++;
      if (mg && mem_addr != 0) shadow[mem_addr] = mem_data;
      if (ag && alu_addr != 0) shadow[alu_addr] = alu_data;
      cnt_m = (a_pend && !ag) ? ((cnt_m == 3'd7) ? cnt_m : cnt_m + 3'd1) : 3'd0;
      if (ag) a_pend = 1'b0;
      if (mg) m_pend = 1'b0;
      tick();
    end
    idle();
    tick();
    tick();
    for (int k = 0; k < 32; k++) begin
      total++;
      if (rf[k] !== shadow[k]) $display("FAIL rand_rf[%0d]: got %h want %h", k, rf[k], shadow[k]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_both();
    test_starvation();
    test_addr0();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
